// File: rtl/rr_mux_4_1_stream_if.sv
// Stream bundle for the 4:1 round-robin mux: four source channels in, one registered stream out.
interface rr_mux_4_1_stream_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       vld;
  logic [3:0]       rdy;
  logic [WIDTH-1:0] y;
  logic [1:0]       sel;
  logic             y_vld;
  logic             y_rdy;

  // Mux side: consumes the sources and the downstream ready, drives the output stream
  modport slave (
    input  d0, d1, d2, d3, vld, y_rdy,
    output rdy, y, sel, y_vld
  );

  // Environment side: drives the sources and the downstream ready
  modport master (
    output d0, d1, d2, d3, vld, y_rdy,
    input  rdy, y, sel, y_vld
  );
endinterface

// File: rtl/rr_mux_4_1_stream.sv
// 4-channel round-robin arbiter feeding a single registered output stage.
// It produces the selected data and the 2-bit select index.
module rr_mux_4_1_stream #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_4_1_stream_if.slave   bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             y_vld_q, y_vld_d;

  logic             load_c;
  logic             win_vld_c;
  logic [1:0]       win_c;
  logic [WIDTH-1:0] win_data_c;
  logic             xfer_in_c;
  logic [3:0]       rdy_c;

  assign load_c    = !y_vld_q || bus.y_rdy;
  assign xfer_in_c = load_c && win_vld_c && !rst;

  // First requester at or above ptr, wrapping 3 -> 0
  always_comb begin
    logic [1:0] idx;
    win_vld_c = 1'b0;
    win_c     = ptr_q;
    idx       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!win_vld_c && bus.vld[idx]) begin
        win_vld_c = 1'b1;
        win_c     = idx;
      end
    end
  end

  // Only the granted channel's data is steered toward the register
  always_comb begin
    win_data_c = '0;
    case (win_c)
      2'd0:    win_data_c = bus.d0;
      2'd1:    win_data_c = bus.d1;
      2'd2:    win_data_c = bus.d2;
      default: win_data_c = bus.d3;
    endcase
  end

  always_comb begin
    rdy_c = 4'b0000;
    if (xfer_in_c) begin
      rdy_c[win_c] = 1'b1;
    end
  end

  // Refill on input transfer, drain on output-only transfer, otherwise hold
  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    y_vld_d = y_vld_q;
    if (xfer_in_c) begin
      y_d     = win_data_c;
      sel_d   = win_c;
      y_vld_d = 1'b1;
      ptr_d   = win_c + 2'd1;
    end else if (y_vld_q && bus.y_rdy) begin
      y_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      y_vld_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign bus.rdy   = rdy_c;
  assign bus.y     = y_q;
  assign bus.sel   = sel_q;
  assign bus.y_vld = y_vld_q;

endmodule

// File: tb/tb_rr_mux_4_1_stream.sv
// Directed bench for rr_mux_4_1_stream: reset, single channel, rotation, skip,
// back-pressure, mid-stream reset and isolation of an X on an idle channel.
module tb_rr_mux_4_1_stream;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_mux_4_1_stream_if #(.WIDTH(WIDTH)) bus ();

  rr_mux_4_1_stream #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ey, input logic [1:0] es, input logic ev);
    check_eq({tag, ".y"},     32'(bus.y),     32'(ey));
    check_eq({tag, ".sel"},   32'(bus.sel),   32'(es));
    check_eq({tag, ".y_vld"}, 32'(bus.y_vld), 32'(ev));
  endtask

  logic [3:0] rr_y [4];
  logic [3:0] x_seq [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rr_y[0] = 4'ha; rr_y[1] = 4'hb; rr_y[2] = 4'hc; rr_y[3] = 4'hd;

    // Reset with every channel requesting
    rst       = 1'b1;
    bus.d0    = 4'ha;
    bus.d1    = 4'hb;
    bus.d2    = 4'hc;
    bus.d3    = 4'hd;
    bus.vld   = 4'hf;
    bus.y_rdy = 1'b1;
    tick();
    tick();
    check_eq("rst.rdy", 32'(bus.rdy), 32'h0);
    check_out("rst", 4'h0, 2'd0, 1'b0);

    // Idle after release
    rst     = 1'b0;
    bus.vld = 4'h0;
    #1;
    check_eq("idle.rdy", 32'(bus.rdy), 32'h0);
    tick();
    check_eq("idle.y_vld", 32'(bus.y_vld), 32'h0);
    check_eq("idle.rdy2", 32'(bus.rdy), 32'h0);

    // Single channel 2
    bus.vld = 4'b0100;
    #1;
    check_eq("single.rdy", 32'(bus.rdy), 32'b0100);
    tick();
    check_out("single", 4'hc, 2'd2, 1'b1);
    bus.vld = 4'h0;
    tick();
    check_eq("single.drain", 32'(bus.y_vld), 32'h0);

    // Re-centre the pointer at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Full rotation with all channels requesting
    bus.vld = 4'hf;
    #1;
    check_eq("rr.rdy0", 32'(bus.rdy), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out($sformatf("rr%0d", i), rr_y[i % 4], 2'(i % 4), 1'b1);
    end
    tick();
    check_out("rr8", 4'ha, 2'd0, 1'b1);

    // Pointer at 1: channel 3 wins before channel 0
    bus.vld = 4'b1001;
    tick();
    check_out("skip3", 4'hd, 2'd3, 1'b1);
    tick();
    check_out("skip0", 4'ha, 2'd0, 1'b1);

    // Back-pressure: load a from channel 0, then stall
    bus.vld = 4'b0001;
    tick();
    check_out("bp.load", 4'ha, 2'd0, 1'b1);
    bus.vld   = 4'hf;
    bus.y_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp.rdy%0d", i), 32'(bus.rdy), 32'h0);
      tick();
      check_out($sformatf("bp.hold%0d", i), 4'ha, 2'd0, 1'b1);
    end
    bus.y_rdy = 1'b1;
    #1;
    check_eq("bp.release.rdy", 32'(bus.rdy), 32'b0010);
    tick();
    check_out("bp.b", 4'hb, 2'd1, 1'b1);
    tick();
    check_out("bp.c", 4'hc, 2'd2, 1'b1);

    // Reset while stalled with a valid item
    bus.y_rdy = 1'b0;
    tick();
    check_out("mid.hold", 4'hc, 2'd2, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid.rdy", 32'(bus.rdy), 32'h0);
    tick();
    check_out("mid.rst", 4'h0, 2'd0, 1'b0);
    rst       = 1'b0;
    bus.y_rdy = 1'b1;
    #1;
    check_eq("mid.rdy0", 32'(bus.rdy), 32'b0001);
    tick();
    check_out("mid.first", 4'ha, 2'd0, 1'b1);

    // X on an idle channel must never reach y; pointer is at 1
    bus.d3  = 4'bxxxx;
    bus.vld = 4'b0011;
    x_seq[0] = 4'hb; x_seq[1] = 4'ha; x_seq[2] = 4'hb; x_seq[3] = 4'ha;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("xiso%0d", i), x_seq[i], 2'(1 - (i % 2)), 1'b1);
    end

    bus.vld = 4'h0;
    tick();
    check_eq("end.drain", 32'(bus.y_vld), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
